// File: rtl/one_wire_master_tx.sv
// 1-Wire bus master: reset/presence sequence and LSB-first byte writes
// on an open-drain line, with a start/busy/done host handshake.
module one_wire_master_tx #(
    parameter int unsigned CLK_MHZ = 100,
    parameter int unsigned T_RSTL  = 480,
    parameter int unsigned T_MSP   = 70,
    parameter int unsigned T_RSTH  = 480,
    parameter int unsigned T_SLOT  = 60,
    parameter int unsigned T_LOW1  = 6,
    parameter int unsigned T_REC   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       tx_done,
    output logic       reset_done,
    output logic       presence_ok,
    inout  wire        one_wire_data
);

    localparam logic [31:0] CYC_RSTL = 32'(T_RSTL * CLK_MHZ);
    localparam logic [31:0] CYC_MSP  = 32'(T_MSP * CLK_MHZ);
    localparam logic [31:0] CYC_RSTH = 32'(T_RSTH * CLK_MHZ);
    localparam logic [31:0] CYC_SLOT = 32'(T_SLOT * CLK_MHZ);
    localparam logic [31:0] CYC_LOW1 = 32'(T_LOW1 * CLK_MHZ);
    localparam logic [31:0] CYC_REC  = 32'(T_REC * CLK_MHZ);

    typedef enum logic [2:0] {
        IDLE, RST_LOW, RST_WAIT, SLOT_LOW, SLOT_HIGH, REC
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        presence_q, presence_d;
    logic        busy_q, tx_done_q, reset_done_q, drive_low_q;
    logic        sync1_q, sync2_q;
    logic        bus_in;

    // Only a solid 0 counts as low; z and x resolve to released.
    always_comb begin
        case (one_wire_data)
            1'b0:    bus_in = 1'b0;
            default: bus_in = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 32'd1;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        presence_d = presence_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_reset) begin
                    state_d = RST_LOW;
                end else if (tx_start) begin
                    state_d   = SLOT_LOW;
                    shift_d   = tx_byte;
                    bit_idx_d = '0;
                end
            end
            RST_LOW: begin
                if (cnt_q == CYC_RSTL - 32'd1) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                end
            end
            RST_WAIT: begin
                if (cnt_q == CYC_MSP) presence_d = ~sync2_q;
                if (cnt_q == CYC_RSTH - 32'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            SLOT_LOW: begin
                if (cnt_q == (shift_q[0] ? CYC_LOW1 : CYC_SLOT) - 32'd1) begin
                    state_d = shift_q[0] ? SLOT_HIGH : REC;
                    cnt_d   = '0;
                end
            end
            SLOT_HIGH: begin
                if (cnt_q == CYC_SLOT - CYC_LOW1 - 32'd1) begin
                    state_d = REC;
                    cnt_d   = '0;
                end
            end
            REC: begin
                if (cnt_q == CYC_REC - 32'd1) begin
                    cnt_d     = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = (bit_idx_q == 3'd7) ? IDLE : SLOT_LOW;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            presence_q   <= 1'b0;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
            reset_done_q <= 1'b0;
            drive_low_q  <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            presence_q   <= presence_d;
            busy_q       <= (state_d != IDLE);
            tx_done_q    <= (state_q == REC) && (state_d == IDLE);
            reset_done_q <= (state_q == RST_WAIT) && (state_d == IDLE);
            drive_low_q  <= (state_d == RST_LOW) || (state_d == SLOT_LOW);
            sync1_q      <= bus_in;
            sync2_q      <= sync1_q;
        end
    end

    assign one_wire_data = drive_low_q ? 1'b0 : 1'bz;
    assign busy          = busy_q;
    assign tx_done       = tx_done_q;
    assign reset_done    = reset_done_q;
    assign presence_ok   = presence_q;

endmodule

// File: tb/tb_one_wire_master_tx.sv
// Bench for one_wire_master_tx: timeline model of each accepted request,
// behavioural 1-Wire slave, per-cycle compare plus literal spot checks.
module tb_one_wire_master_tx;
    localparam int CLK_MHZ = 5;
    localparam int CYC_RSTL = 480 * CLK_MHZ;
    localparam int CYC_MSP  = 70 * CLK_MHZ;
    localparam int CYC_RSTH = 480 * CLK_MHZ;
    localparam int CYC_SLOT = 60 * CLK_MHZ;
    localparam int CYC_LOW1 = 6 * CLK_MHZ;
    localparam int CYC_REC  = 5 * CLK_MHZ;
    localparam int BIT_LEN  = CYC_SLOT + CYC_REC;
    localparam int BYTE_LEN = 8 * BIT_LEN;
    localparam int RST_LEN  = CYC_RSTL + CYC_RSTH;
    localparam int PRES_T   = CYC_RSTL + CYC_MSP + 1;
    localparam int SAMP_CYC = 15 * CLK_MHZ;
    localparam int P_BEG    = 20 * CLK_MHZ;
    localparam int P_END    = 140 * CLK_MHZ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_reset = 1'b0;
    logic tx_start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic busy, tx_done, reset_done, presence_ok;
    wire  bus;
    logic slave_low = 1'b0;

    assign bus = slave_low ? 1'b0 : 1'bz;
    pullup (bus);

    one_wire_master_tx #(.CLK_MHZ(CLK_MHZ)) dut (
        .clk(clk), .rst(rst), .start_reset(start_reset), .tx_start(tx_start),
        .tx_byte(tx_byte), .busy(busy), .tx_done(tx_done), .reset_done(reset_done),
        .presence_ok(presence_ok), .one_wire_data(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one timeline per accepted request
    longint n_edge = 0;
    longint st = 0;
    int     op = 0;          // 0 none, 1 reset sequence, 2 byte
    logic [7:0] m_byte = 8'h00;
    logic   m_pres = 1'b0;
    logic   slave_present = 1'b1;

    function automatic longint op_len(input int o);
        return (o == 1) ? RST_LEN : (o == 2) ? BYTE_LEN : 0;
    endfunction

    function automatic bit byte_low(input logic [7:0] b, input longint t);
        longint off;
        int bi;
        off = t % BIT_LEN;
        bi  = int'(t / BIT_LEN);
        if (bi > 7) return 1'b0;
        return off < (b[bi] ? CYC_LOW1 : CYC_SLOT);
    endfunction

    always @(posedge clk) begin
        n_edge++;
        if (rst) begin
            op     = 0;
            m_pres = 1'b0;
        end else begin
            if (op == 0 || (n_edge - 1 - st) >= op_len(op)) begin
                if (start_reset) begin
                    op = 1; st = n_edge;
                end else if (tx_start) begin
                    op = 2; st = n_edge; m_byte = tx_byte;
                end
            end
            if (op == 1 && (n_edge - st) == PRES_T) m_pres = slave_present;
        end
    end

    // ---------------- per-cycle compare
    bit     chk_en = 1'b0;
    longint ct;
    logic [3:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_en) begin
            ct = n_edge - st;
            exp_v[3] = (op != 0) && ct < op_len(op);
            exp_v[2] = (op == 2) && ct == BYTE_LEN;
            exp_v[1] = (op == 1) && ct == RST_LEN;
            exp_v[0] = slave_low || (op == 1 && ct < CYC_RSTL) ||
                       (op == 2 && ct < BYTE_LEN && byte_low(m_byte, ct));
            act_v = {busy, tx_done, reset_done, bus === 1'b0};
            chk("busy/tx_done/reset_done/bus_low", 32'(act_v), 32'(exp_v));
            if (!(op == 1 && ct >= PRES_T - 3 && ct <= PRES_T + 3))
                chk("presence_ok", 32'(presence_ok), 32'(m_pres));
        end
    end

    // ---------------- monitors
    int busy_run = 0, last_busy_len = 0, tx_done_cnt = 0, rst_done_cnt = 0;
    always @(negedge clk) begin
        if (busy) busy_run++;
        else if (busy_run > 0) begin last_busy_len = busy_run; busy_run = 0; end
        if (tx_done) tx_done_cnt++;
        if (reset_done) rst_done_cnt++;
    end

    // ---------------- behavioural slave: presence pulse and slot sampling
    int widths[$];
    int low_run = 0, samp_t = -1, pres_t = -1, rx_cnt = 0, rx_count = 0;
    int clr_req = 0, clr_seen = 0;
    bit prev_low = 1'b0, cur_low, run_slave = 1'b0;
    logic [7:0] rx_sr = 8'h00, rx_last = 8'h00;
    always @(posedge clk) begin
        #2;
        if (clr_req != clr_seen) begin clr_seen = clr_req; rx_cnt = 0; samp_t = -1; end
        cur_low = (bus === 1'b0);
        if (cur_low) begin
            if (!prev_low) begin
                run_slave = slave_low; low_run = 0;
                if (!slave_low) samp_t = 0;
            end
            low_run++;
        end else if (prev_low) begin
            if (!run_slave) widths.push_back(low_run);
            if (low_run >= CYC_RSTL / 2) begin rx_cnt = 0; samp_t = -1; pres_t = 0; end
        end
        if (samp_t >= 0) begin
            samp_t++;
            if (samp_t == SAMP_CYC) begin
                rx_sr = {(bus !== 1'b0), rx_sr[7:1]};
                samp_t = -1;
                rx_cnt++;
                if (rx_cnt == 8) begin rx_last = rx_sr; rx_count++; rx_cnt = 0; end
            end
        end
        if (pres_t >= 0) begin pres_t++; if (pres_t >= P_END) pres_t = -1; end
        slave_low = slave_present && pres_t >= P_BEG && pres_t < P_END;
        prev_low = cur_low;
    end

    // ---------------- stimulus
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        tx_byte = b; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0;
    endtask

    task automatic do_reset_seq();
        start_reset = 1'b1; @(negedge clk); start_reset = 1'b0;
    endtask

    task automatic wait_done(input bit want_rst, input string name);
        int k;
        k = 0;
        while (!(want_rst ? reset_done : tx_done) && k < 20000) begin
            @(negedge clk); k++;
        end
        n_checks++;
        if (k >= 20000) begin
            n_err++;
            $display("FAIL %s: no done pulse within 20000 cycles", name);
        end
    endtask

    int  w_base, rxc, tdc;
    longint d1, d2;
    logic [7:0] rb;
    int  a5_w[8] = '{30, 300, 30, 300, 300, 30, 300, 30};

    initial begin
        tick(3);
        chk_en = 1'b1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset presence_ok", 32'(presence_ok), 32'd0);
        chk("reset bus released", 32'(bus === 1'b0), 32'd0);
        rst = 1'b0;
        tick(2);

        slave_present = 1'b1;
        do_reset_seq();
        wait_done(1'b1, "reset seq present");
        tick(2);
        chk("reset low width", 32'(widths[widths.size()-1]), 32'd2400);
        chk("reset busy length", 32'(last_busy_len), 32'd4800);
        chk("presence with slave", 32'(presence_ok), 32'd1);

        slave_present = 1'b0;
        do_reset_seq();
        wait_done(1'b1, "reset seq absent");
        tick(2);
        chk("presence no slave", 32'(presence_ok), 32'd0);
        chk("busy after reset", 32'(busy), 32'd0);

        w_base = widths.size(); rxc = rx_count;
        send(8'hA5);
        wait_done(1'b0, "tx A5");
        tick(2);
        for (int i = 0; i < 8; i++)
            chk($sformatf("A5 low width bit%0d", i), 32'(widths[w_base+i]), 32'(a5_w[i]));
        chk("A5 rx byte", 32'(rx_last), 32'hA5);
        chk("A5 rx count", 32'(rx_count), 32'(rxc + 1));
        chk("byte busy length", 32'(last_busy_len), 32'd2600);

        slave_present = 1'b1;
        tdc = tx_done_cnt;
        tx_byte = 8'h33; tx_start = 1'b1; start_reset = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; start_reset = 1'b0;
        wait_done(1'b1, "arbitration reset");
        tick(10);
        chk("arbitration no tx_done", 32'(tx_done_cnt), 32'(tdc));

        send(8'h5A);
        tick(1000);
        tx_byte = 8'hFF; tx_start = 1'b1; @(negedge clk); tx_start = 1'b0;
        wait_done(1'b0, "tx 5A");
        tick(2);
        chk("mid-byte request ignored", 32'(rx_last), 32'h5A);

        tdc = tx_done_cnt;
        send(8'h00);
        tick(3 * BIT_LEN + 100);
        chk("bit3 low before abort", 32'(bus === 1'b0), 32'd1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("abort bus released", 32'(bus === 1'b0), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort presence cleared", 32'(presence_ok), 32'd0);
        tick(3000);
        chk("abort no tx_done", 32'(tx_done_cnt), 32'(tdc));
        clr_req++;
        tick(5);

        send(8'h3C);
        wait_done(1'b0, "tx 3C");
        tick(2);
        chk("3C rx byte", 32'(rx_last), 32'h3C);

        send(8'h80);
        wait_done(1'b0, "tx 80");
        d1 = n_edge;
        chk("80 rx byte", 32'(rx_last), 32'h80);
        send(8'h01);
        wait_done(1'b0, "tx 01 back-to-back");
        d2 = n_edge;
        chk("b2b done spacing", 32'(d2 - d1), 32'd2601);
        chk("01 rx byte", 32'(rx_last), 32'h01);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            tick($urandom_range(0, 20));
            send(rb);
            wait_done(1'b0, "tx random");
            chk("random rx byte", 32'(rx_last), 32'(rb));
        end
        tick(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
